// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - shared SR resolution constants and next-state function
package sr_bank_pkg;

  localparam int MODE_RST_DOM = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_HOLD    = 2;
  localparam int MODE_TOGGLE  = 3;

  // Next state of one SR channel; s=r=1 is resolved by mode so the result is never X.
  function automatic logic next_q(input logic q, input logic s, input logic r, input int mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10:   nq = 1'b1;
      2'b01:   nq = 1'b0;
      2'b11: begin
        case (mode)
          MODE_RST_DOM: nq = 1'b0;
          MODE_SET_DOM: nq = 1'b1;
          MODE_HOLD:    nq = q;
          MODE_TOGGLE:  nq = ~q;
          default:      nq = 1'b0;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// rtl/sr_ff_cell.sv - one registered SR channel with complementary output
module sr_ff_cell
  import sr_bank_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic q_nxt;

  // Resolve the request against the current state.
  always_comb begin
    q_nxt = next_q(q, s, r, MODE);
  end

  // q and q_bar share one edge so they are complementary in every cycle, reset included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= 1'b0;
      q_bar <= 1'b1;
    end else if (en) begin
      q     <= q_nxt;
      q_bar <= ~q_nxt;
    end
  end

endmodule

// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - WIDTH-channel SR flip-flop bank with conflict flag and counter (option: SR_BANK_EDGE_EN)
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;
  logic             conflict_evt;

`ifdef SR_BANK_EDGE_EN
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] r_d;

  // Request history is tracked every clock, independent of en, so a held request acts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d <= '0;
      r_d <= '0;
    end else begin
      s_d <= s;
      r_d <= r;
    end
  end

  assign s_eff = s & ~s_d;
  assign r_eff = r & ~r_d;
`else
  assign s_eff = s;
  assign r_eff = r;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .MODE (MODE)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .s     (s_eff[i]),
      .r     (r_eff[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  // One event per cycle no matter how many channels collide.
  assign conflict_evt = en & (|(s_eff & r_eff));

  // Registered conflict pulse, aligned with the q update it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else begin
      conflict <= conflict_evt;
    end
  end

  // Saturating conflict counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_cnt) begin
      conflict_cnt <= '0;
    end else if (conflict_evt && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
